// File: rtl/ch7301_i2c_init.sv
// CH7301 DVI transmitter bring-up: writes a fixed 7-entry register table over I2C, then flags done or err.
// Optional CH7301_RETRY_EN: a NACKed entry is retried until its 4th consecutive NACK.
module ch7301_i2c_init #(
  parameter int         CLK_DIV    = 250,
  parameter logic [6:0] DEV_ADDR   = 7'h76,
  parameter bit         AUTO_START = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic done,
  output logic err,
  output logic scl_oe,
  output logic sda_oe,
  input  logic sda_i
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  // FIN and ERR are folded into the final GAP tick: flags update on that edge and the FSM returns to IDLE.
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_BIT,
    S_STOP,
    S_GAP
  } state_t;

  state_t           state_q;
  logic [1:0]       phase_q;
  logic [4:0]       bit_q;
  logic [2:0]       idx_q;
  logic [DIV_W-1:0] div_q;
  logic             nack_q;
  logic             auto_q;
  logic             busy_q, done_q, err_q, scl_oe_q, sda_oe_q;
`ifdef CH7301_RETRY_EN
  logic [1:0]       retry_q;
`endif

  logic        tick;
  logic [15:0] entry;
  logic [26:0] frame;
  logic        ack_bit;

  always_comb begin
    case (idx_q)
      3'd0:    entry = 16'h49C0;
      3'd1:    entry = 16'h2109;
      3'd2:    entry = 16'h3308;
      3'd3:    entry = 16'h3416;
      3'd4:    entry = 16'h3660;
      3'd5:    entry = 16'h1F80;
      default: entry = 16'h1C04;
    endcase
  end

  // ACK slots carry a 1 so that the line is released while the slave answers.
  assign frame   = {DEV_ADDR, 1'b0, 1'b1, entry[15:8], 1'b1, entry[7:0], 1'b1};
  assign tick    = (div_q == DIV_LAST);
  assign ack_bit = (bit_q == 5'd8) || (bit_q == 5'd17) || (bit_q == 5'd26);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      phase_q  <= 2'd0;
      bit_q    <= 5'd0;
      idx_q    <= 3'd0;
      div_q    <= '0;
      nack_q   <= 1'b0;
      auto_q   <= AUTO_START;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      scl_oe_q <= 1'b0;
      sda_oe_q <= 1'b0;
`ifdef CH7301_RETRY_EN
      retry_q  <= 2'd0;
`endif
    end else begin
      if (state_q == S_IDLE || tick) div_q <= '0;
      else                           div_q <= div_q + 1'b1;

      case (state_q)
        S_IDLE: begin
          if (start || auto_q) begin
            auto_q   <= 1'b0;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            idx_q    <= 3'd0;
            nack_q   <= 1'b0;
            state_q  <= S_START;
            phase_q  <= 2'd0;
            sda_oe_q <= 1'b1;
            scl_oe_q <= 1'b0;
`ifdef CH7301_RETRY_EN
            retry_q  <= 2'd0;
`endif
          end
        end

        S_START: if (tick) begin
          if (phase_q == 2'd0) begin
            scl_oe_q <= 1'b1;
            phase_q  <= 2'd1;
          end else begin
            state_q  <= S_BIT;
            bit_q    <= 5'd0;
            phase_q  <= 2'd0;
            sda_oe_q <= ~frame[26];
          end
        end

        S_BIT: if (tick) begin
          case (phase_q)
            2'd0: begin
              scl_oe_q <= 1'b0;
              phase_q  <= 2'd1;
            end
            2'd1: phase_q <= 2'd2;
            2'd2: begin
              if (ack_bit && sda_i) nack_q <= 1'b1;
              scl_oe_q <= 1'b1;
              phase_q  <= 2'd3;
            end
            default: begin
              phase_q <= 2'd0;
              if (nack_q || bit_q == 5'd26) begin
                state_q  <= S_STOP;
                sda_oe_q <= 1'b1;
                scl_oe_q <= 1'b0;
              end else begin
                bit_q    <= bit_q + 5'd1;
                sda_oe_q <= ~frame[5'd25 - bit_q];
              end
            end
          endcase
        end

        S_STOP: if (tick) begin
          if (phase_q == 2'd0) begin
            sda_oe_q <= 1'b0;
            phase_q  <= 2'd1;
          end else begin
            state_q <= S_GAP;
            phase_q <= 2'd0;
          end
        end

        S_GAP: if (tick) begin
          if (phase_q != 2'd3) begin
            phase_q <= phase_q + 2'd1;
          end else if (nack_q) begin
`ifdef CH7301_RETRY_EN
            if (retry_q == 2'd3) begin
              err_q   <= 1'b1;
              busy_q  <= 1'b0;
              idx_q   <= 3'd0;
              nack_q  <= 1'b0;
              retry_q <= 2'd0;
              state_q <= S_IDLE;
            end else begin
              retry_q  <= retry_q + 2'd1;
              nack_q   <= 1'b0;
              state_q  <= S_START;
              phase_q  <= 2'd0;
              sda_oe_q <= 1'b1;
            end
`else
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            idx_q   <= 3'd0;
            nack_q  <= 1'b0;
            state_q <= S_IDLE;
`endif
          end else if (idx_q != 3'd6) begin
            idx_q    <= idx_q + 3'd1;
            state_q  <= S_START;
            phase_q  <= 2'd0;
            sda_oe_q <= 1'b1;
`ifdef CH7301_RETRY_EN
            retry_q  <= 2'd0;
`endif
          end else begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            idx_q   <= 3'd0;
            state_q <= S_IDLE;
`ifdef CH7301_RETRY_EN
            retry_q <= 2'd0;
`endif
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;
  assign scl_oe = scl_oe_q;
  assign sda_oe = sda_oe_q;

endmodule

// File: tb/tb_ch7301_i2c_init.sv
// Bench for ch7301_i2c_init: open-drain bus with a behavioural I2C slave that can NACK on demand,
// plus a second instance with AUTO_START=1 whose SDA input always acknowledges.
module tb_ch7301_i2c_init;
  localparam int CLK_DIV = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic busy, done, err, scl_oe, sda_oe, sda_i;
  logic busy_a, done_a, err_a, scl_oe_a, sda_oe_a;
  logic s_drive = 1'b0;

  wire scl_line = ~scl_oe;
  wire sda_line = ~(sda_oe | s_drive);
  assign sda_i = sda_line;

  always #5 clk = ~clk;

  ch7301_i2c_init #(.CLK_DIV(CLK_DIV), .DEV_ADDR(7'h76), .AUTO_START(1'b0)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
    .scl_oe(scl_oe), .sda_oe(sda_oe), .sda_i(sda_i)
  );

  ch7301_i2c_init #(.CLK_DIV(CLK_DIV), .DEV_ADDR(7'h76), .AUTO_START(1'b1)) dut_a (
    .clk(clk), .rst(rst), .start(1'b0), .busy(busy_a), .done(done_a), .err(err_a),
    .scl_oe(scl_oe_a), .sda_oe(sda_oe_a), .sda_i(1'b0)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // ---------------- I2C slave model, sampled on the falling clock edge ----------------
  logic       prev_scl = 1'b1, prev_sda = 1'b1;
  logic       s_active = 1'b0, s_nacked = 1'b0;
  int         s_bit = 0, s_byte = 0;
  logic [7:0] s_shift = 8'h00;
  logic [7:0] s_bytes [3];
  int         nack_pos = 0, nack_left = 0;
  logic [7:0] nack_reg = 8'h00;
  logic [23:0] wr_log [16];
  int         wr_cnt = 0, stop_cnt = 0, start_cnt = 0;

  always @(negedge clk) begin
    logic cs, cd;
    cs = scl_line;
    cd = sda_line;
    if (prev_scl && cs && prev_sda && !cd) begin
      start_cnt++;
      s_active = 1'b1; s_bit = 0; s_byte = 0; s_nacked = 1'b0; s_drive = 1'b0;
    end else if (prev_scl && cs && !prev_sda && cd) begin
      stop_cnt++;
      if (s_active && s_byte == 3 && !s_nacked && wr_cnt < 16) begin
        wr_log[wr_cnt] = {s_bytes[0], s_bytes[1], s_bytes[2]};
        wr_cnt++;
      end
      s_active = 1'b0;
      s_drive  = 1'b0;
    end else if (s_active && !prev_scl && cs) begin
      if (s_bit < 8) s_shift = {s_shift[6:0], cd};
      s_bit++;
    end else if (s_active && prev_scl && !cs) begin
      if (s_bit == 8) begin
        if (s_byte < 3) s_bytes[s_byte] = s_shift;
        if (nack_left > 0 && s_byte == nack_pos &&
            (nack_pos == 0 || (nack_pos == 1 && s_shift == nack_reg) ||
             (nack_pos == 2 && s_bytes[1] == nack_reg))) begin
          nack_left--;
          s_nacked = 1'b1;
          s_drive  = 1'b0;
        end else begin
          s_drive = 1'b1;
        end
      end else if (s_bit == 9) begin
        s_drive = 1'b0;
        s_bit   = 0;
        s_byte++;
      end
    end
    prev_scl = cs;
    prev_sda = cd;
  end

  // ---------------- scenario table ----------------
  typedef struct {
    string      tag;
    int         nack_pos;
    logic [7:0] nack_reg;
    int         nack_left;
    bit         inject;
    bit         exp_done;
    bit         exp_err;
    int         exp_cycles;
    int         exp_writes;
    int         exp_stops;
  } scen_t;

  logic [15:0] exp_tab [7] = '{16'h49C0, 16'h2109, 16'h3308, 16'h3416, 16'h3660, 16'h1F80, 16'h1C04};

  task automatic run_scen(input scen_t s);
    int  cyc;
    bit  seen;
    int  n;
    wr_cnt = 0; stop_cnt = 0; start_cnt = 0;
    nack_pos = s.nack_pos; nack_reg = s.nack_reg; nack_left = s.nack_left;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk({s.tag, "/flags_on_accept"}, 32'({busy, done, err}), 32'b100);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 10000) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      start = s.inject && (cyc == 10 || cyc == 500);
      if (cyc == 500 && s.exp_cycles > 500)
        chk({s.tag, "/flags_mid_run"}, 32'({busy, done, err}), 32'b100);
      if (done || err) seen = 1'b1;
    end
    start = 1'b0;
    chk({s.tag, "/finished"}, 32'(seen), 32'd1);
    chk({s.tag, "/cycles"}, 32'(cyc), 32'(s.exp_cycles));
    chk({s.tag, "/done_err"}, 32'({done, err}), 32'({s.exp_done, s.exp_err}));
    chk({s.tag, "/busy"}, 32'(busy), 32'd0);
    chk({s.tag, "/lines"}, 32'({scl_oe, sda_oe}), 32'd0);
    chk({s.tag, "/writes"}, 32'(wr_cnt), 32'(s.exp_writes));
    chk({s.tag, "/stops"}, 32'(stop_cnt), 32'(s.exp_stops));
    n = (wr_cnt < s.exp_writes) ? wr_cnt : s.exp_writes;
    for (int i = 0; i < n; i++)
      chk($sformatf("%s/write%0d", s.tag, i), 32'(wr_log[i]), 32'({8'hEC, exp_tab[i]}));
  endtask

  initial begin
    scen_t sc [7];
    int    cyc;
    bit    seen;

    sc[0] = '{"all_ack", 0, 8'h00, 0, 1'b0, 1'b1, 1'b0, 3248, 7, 7};
`ifdef CH7301_RETRY_EN
    sc[1] = '{"nack_r21_data", 2, 8'h21, 99, 1'b0, 1'b0, 1'b1, 2320, 1, 5};
    sc[2] = '{"nack_r33_data", 2, 8'h33, 99, 1'b0, 1'b0, 1'b1, 2784, 2, 6};
    sc[3] = '{"nack_r36_reg",  1, 8'h36, 99, 1'b0, 1'b0, 1'b1, 3136, 4, 8};
    sc[4] = '{"nack_addr_x1",  0, 8'h00, 1,  1'b0, 1'b1, 1'b0, 3424, 7, 8};
    sc[5] = '{"nack_addr_x4",  0, 8'h00, 4,  1'b0, 1'b0, 1'b1, 704,  0, 4};
`else
    sc[1] = '{"nack_r21_data", 2, 8'h21, 99, 1'b0, 1'b0, 1'b1, 928,  1, 2};
    sc[2] = '{"nack_r33_data", 2, 8'h33, 99, 1'b0, 1'b0, 1'b1, 1392, 2, 3};
    sc[3] = '{"nack_r36_reg",  1, 8'h36, 99, 1'b0, 1'b0, 1'b1, 2176, 4, 5};
    sc[4] = '{"nack_addr_x1",  0, 8'h00, 1,  1'b0, 1'b0, 1'b1, 176,  0, 1};
    sc[5] = '{"nack_addr_x4",  0, 8'h00, 4,  1'b0, 1'b0, 1'b1, 176,  0, 1};
`endif
    sc[6] = '{"start_repeat", 0, 8'h00, 0, 1'b1, 1'b1, 1'b0, 3248, 7, 7};

    // Reset state of both instances, then auto-start of the AUTO_START=1 copy.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset/outputs", 32'({busy, done, err, scl_oe, sda_oe}), 32'd0);
    chk("reset/outputs_auto", 32'({busy_a, done_a, err_a, scl_oe_a, sda_oe_a}), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("auto/busy_first_cycle", 32'(busy_a), 32'd1);
    chk("auto/start_cond_lines", 32'({scl_oe_a, sda_oe_a}), 32'b01);
    chk("auto/no_autostart_when_off", 32'(busy), 32'd0);
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 10000) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (done_a || err_a) seen = 1'b1;
    end
    chk("auto/cycles", 32'(cyc), 32'd3248);
    chk("auto/done_err", 32'({done_a, err_a, busy_a}), 32'b100);
    chk("auto/other_idle", 32'({busy, scl_oe, sda_oe}), 32'd0);

    for (int i = 0; i < 7; i++) run_scen(sc[i]);

    // Asynchronous reset in the middle of entry 3's data byte.
    wr_cnt = 0; stop_cnt = 0; nack_left = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!(wr_cnt == 3 && s_active && s_byte == 2 && s_bit == 4) && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    chk("rst_mid/reached_entry3_data", 32'(cyc < 5000), 32'd1);
    chk("rst_mid/busy_before", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid/outputs_immediate", 32'({busy, done, err, scl_oe, sda_oe}), 32'd0);
    chk("rst_mid/outputs_auto", 32'({busy_a, done_a, err_a, scl_oe_a, sda_oe_a}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    sc[0].tag = "after_rst";
    run_scen(sc[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
